// File: rtl/uart_rx_wide_packer.sv
// 8N1 UART receiver feeding a byte-to-word packer and a show-ahead word FIFO.
// Define UART_PARITY_EN to add a parity bit (PARITY_ODD) and the sticky parity_err output.
module uart_rx_wide_packer #(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int OUT_W      = 256,
  parameter int FIFO_DEPTH = 1024,
  parameter int AFULL_TH   = FIFO_DEPTH - 16,
  parameter int BYTE_ORDER = 0,
  parameter int IDLE_FLUSH = 0
`ifdef UART_PARITY_EN
  , parameter int PARITY_ODD = 0
`endif
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          uart_rxd,
  input  logic                          clr_err,
  input  logic                          dout_ready,
  output logic [OUT_W-1:0]              dout,
  output logic                          dout_vld,
  output logic [$clog2(FIFO_DEPTH):0]   wr_water_level,
  output logic                          almost_full,
  output logic                          frame_err,
  output logic                          overflow
`ifdef UART_PARITY_EN
  , output logic                        parity_err
`endif
);

  localparam int BIT_CNT   = CLK_FREQ / UART_BPS;
  localparam int CW        = (BIT_CNT > 2) ? $clog2(BIT_CNT) : 1;
  localparam int NB        = OUT_W / 8;
  localparam int BCW       = (NB > 1) ? $clog2(NB) : 1;
  localparam int AW        = $clog2(FIFO_DEPTH);
  localparam int FLUSH_CYC = IDLE_FLUSH * BIT_CNT;
  localparam int ICW       = (FLUSH_CYC > 2) ? $clog2(FLUSH_CYC) : 1;

  localparam logic [CW-1:0]  BIT_LAST  = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0]  HALF_LAST = CW'(BIT_CNT / 2 - 1);
  localparam logic [BCW-1:0] LANE_LAST = BCW'(NB - 1);
  localparam logic [ICW-1:0] IDLE_LAST = ICW'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);
  localparam logic [AW:0]    DEPTH_W   = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]    AFULL_W   = (AW + 1)'(AFULL_TH);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd4;
`ifdef UART_PARITY_EN
  localparam logic [2:0] S_PARITY     = 3'd3;
  localparam logic [2:0] S_AFTER_DATA = S_PARITY;

  function automatic logic parity_bit(input logic [7:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

  logic par_bad_q, par_bad_d, parity_err_q, parity_err_d, par_set_s;
`else
  localparam logic [2:0] S_AFTER_DATA = S_STOP;
`endif

  logic              rxd_s1_q, rxd_s2_q, rxd_prev_q, fall_s;
  logic [2:0]        state_q, state_d, bit_idx_q, bit_idx_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [7:0]        shift_q, shift_d;
  logic              ferr_wait_q, ferr_wait_d, byte_stb_q, byte_stb_d, frame_set_s;
  logic [ICW-1:0]    idle_cnt_q, idle_cnt_d;
  logic [BCW-1:0]    byte_cnt_q, byte_cnt_d, lane_s;
  logic [OUT_W-1:0]  word_q, word_d, word_ins_s, push_word_q, push_word_d;
  logic              push_q, push_d, flush_s;
  logic [OUT_W-1:0]  mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              pop_s, full_s, push_ok_s, ovf_set_s;
  logic              almost_full_q, almost_full_d, frame_err_q, frame_err_d, overflow_q, overflow_d;

  assign fall_s = rxd_prev_q & ~rxd_s2_q;

  // Receiver FSM: half-bit start check, then mid-bit sampling of data and stop bits.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    ferr_wait_d = ferr_wait_q;
    byte_stb_d  = 1'b0;
    frame_set_s = 1'b0;
`ifdef UART_PARITY_EN
    par_bad_d   = par_bad_q;
    par_set_s   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (fall_s) state_d = S_START;
        else        state_d = S_IDLE;
      end
      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = 3'd0;
          if (rxd_s2_q) state_d = S_IDLE;
          else          state_d = S_DATA;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {rxd_s2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = S_AFTER_DATA;
          else                   state_d = S_DATA;
        end else begin
          state_d = S_DATA;
        end
      end
`ifdef UART_PARITY_EN
      S_PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          state_d   = S_STOP;
          par_bad_d = (rxd_s2_q != parity_bit(shift_q, (PARITY_ODD != 0)));
          par_set_s = par_bad_d;
        end else begin
          state_d = S_PARITY;
        end
      end
`endif
      S_STOP: begin
        // After a bad stop bit, hold here until the line returns high.
        if (ferr_wait_q) begin
          cnt_d = '0;
          if (rxd_s2_q) begin
            state_d     = S_IDLE;
            ferr_wait_d = 1'b0;
          end else begin
            state_d = S_STOP;
          end
        end else if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rxd_s2_q) begin
            state_d = S_IDLE;
`ifdef UART_PARITY_EN
            byte_stb_d = ~par_bad_q;
`else
            byte_stb_d = 1'b1;
`endif
          end else begin
            frame_set_s = 1'b1;
            ferr_wait_d = 1'b1;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Idle timer and packer: place each byte in its lane, push on wrap or idle flush.
  always_comb begin
    if (state_q != S_IDLE)          idle_cnt_d = '0;
    else if (idle_cnt_q != IDLE_LAST) idle_cnt_d = idle_cnt_q + 1'b1;
    else                            idle_cnt_d = idle_cnt_q;

    flush_s = (IDLE_FLUSH > 0) && (state_q == S_IDLE) && (idle_cnt_q == IDLE_LAST) &&
              (byte_cnt_q != '0);
    if (BYTE_ORDER != 0) lane_s = LANE_LAST - byte_cnt_q;
    else                 lane_s = byte_cnt_q;
    word_ins_s = word_q;
    word_ins_s[{lane_s, 3'b000} +: 8] = shift_q;

    push_d      = 1'b0;
    push_word_d = push_word_q;
    word_d      = word_q;
    byte_cnt_d  = byte_cnt_q;
    if (byte_stb_q) begin
      if (byte_cnt_q == LANE_LAST) begin
        push_d      = 1'b1;
        push_word_d = word_ins_s;
        word_d      = '0;
        byte_cnt_d  = '0;
      end else begin
        word_d     = word_ins_s;
        byte_cnt_d = byte_cnt_q + 1'b1;
      end
    end else if (flush_s) begin
      push_d      = 1'b1;
      push_word_d = word_q;
      word_d      = '0;
      byte_cnt_d  = '0;
    end else begin
      push_d = 1'b0;
    end
  end

  // FIFO pointers, occupancy and sticky error flags (a set beats a same-cycle clear).
  always_comb begin
    pop_s     = dout_vld & dout_ready;
    full_s    = (count_q == DEPTH_W);
    push_ok_s = push_q & (~full_s | pop_s);
    ovf_set_s = push_q & full_s & ~pop_s;
    wr_ptr_d  = push_ok_s ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d  = pop_s ? rd_ptr_q + 1'b1 : rd_ptr_q;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    almost_full_d = (count_d >= AFULL_W);
    frame_err_d   = frame_set_s ? 1'b1 : (clr_err ? 1'b0 : frame_err_q);
    overflow_d    = ovf_set_s ? 1'b1 : (clr_err ? 1'b0 : overflow_q);
`ifdef UART_PARITY_EN
    parity_err_d  = par_set_s ? 1'b1 : (clr_err ? 1'b0 : parity_err_q);
`endif
  end

  // Word storage; contents need no reset because reads are masked by dout_vld.
  always_ff @(posedge sys_clk) begin
    if (push_ok_s) mem_q[wr_ptr_q] <= push_word_q;
  end

  // State registers with synchronous reset; the rxd synchroniser idles high.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rxd_s1_q      <= 1'b1;
      rxd_s2_q      <= 1'b1;
      rxd_prev_q    <= 1'b1;
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      bit_idx_q     <= 3'd0;
      shift_q       <= 8'd0;
      ferr_wait_q   <= 1'b0;
      byte_stb_q    <= 1'b0;
      idle_cnt_q    <= '0;
      byte_cnt_q    <= '0;
      word_q        <= '0;
      push_q        <= 1'b0;
      push_word_q   <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      frame_err_q   <= 1'b0;
      overflow_q    <= 1'b0;
`ifdef UART_PARITY_EN
      par_bad_q     <= 1'b0;
      parity_err_q  <= 1'b0;
`endif
    end else begin
      rxd_s1_q      <= uart_rxd;
      rxd_s2_q      <= rxd_s1_q;
      rxd_prev_q    <= rxd_s2_q;
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      ferr_wait_q   <= ferr_wait_d;
      byte_stb_q    <= byte_stb_d;
      idle_cnt_q    <= idle_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      word_q        <= word_d;
      push_q        <= push_d;
      push_word_q   <= push_word_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      almost_full_q <= almost_full_d;
      frame_err_q   <= frame_err_d;
      overflow_q    <= overflow_d;
`ifdef UART_PARITY_EN
      par_bad_q     <= par_bad_d;
      parity_err_q  <= parity_err_d;
`endif
    end
  end

  assign dout_vld       = (count_q != '0);
  assign dout           = dout_vld ? mem_q[rd_ptr_q] : '0;
  assign wr_water_level = count_q;
  assign almost_full    = almost_full_q;
  assign frame_err      = frame_err_q;
  assign overflow       = overflow_q;
`ifdef UART_PARITY_EN
  assign parity_err     = parity_err_q;
`endif

endmodule

// File: doc/uart_rx_wide_packer.md
Name: uart_rx_wide_packer

Overview:
- Parametrised successor to the UART receive front end: serial bytes in, packed wide words out to the accelerator's input control path.
- Integrates the 8N1 receiver, a byte-to-word packer of configurable width, and an output FIFO of configurable depth with a ready/valid read side.
- Adds byte-order selection, idle-timeout flush of partial words, framing and overflow error flags, and a programmable almost-full threshold.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- UART_BPS, 115200, baud rate. BIT_CNT = CLK_FREQ/UART_BPS, integer-truncated.
- OUT_W, 256, packed word width. Multiple of 8, at least 8. NB = OUT_W/8.
- FIFO_DEPTH, 1024, FIFO depth in words. Power of 2, at least 4.
- AFULL_TH, FIFO_DEPTH-16, almost_full threshold in words.
- BYTE_ORDER, 0, placement of the first received byte. 0 = dout[7:0], 1 = dout[OUT_W-1:OUT_W-8].
- IDLE_FLUSH, 0, idle timeout in bit periods. 0 disables flushing.

Ports:
- sys_clk  in  1  system clock.
- sys_rst  in  1  synchronous reset, active-high.
- uart_rxd  in  1  asynchronous serial input. Idle level is 1.
- clr_err  in  1  one-cycle pulse; clears frame_err and overflow.
- dout_ready  in  1  downstream accepts a word.
- dout  out  OUT_W  FIFO head word (show-ahead).
- dout_vld  out  1  FIFO not empty.
- wr_water_level  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy in words.
- almost_full  out  1  high when wr_water_level >= AFULL_TH.
- frame_err  out  1  sticky; set when a stop bit is sampled as 0.
- overflow  out  1  sticky; set when a word is dropped because the FIFO is full.

Behaviour:
- Reset: every output is 0 and the FIFO is empty. The two-flop rxd synchroniser resets to 1. The receiver returns to IDLE, the byte counter to 0, the partial word to 0. Reset mid-frame discards the partial byte and the partial word.
- Receiver FSM (states IDLE, START, DATA, [PARITY], STOP):
  - IDLE: a falling edge on the synchronised rxd moves to START.
  - START: at BIT_CNT/2 cycles, rxd=0 moves to DATA; rxd=1 is a glitch and returns to IDLE.
  - DATA: samples one bit every BIT_CNT cycles, LSB first, 8 bits.
  - STOP: samples the stop bit. On 1, assert byte strobe the next cycle. On 0, set frame_err, discard the byte, and wait for rxd=1 before returning to IDLE.
- Packer:
  - Each byte strobe writes the byte into lane byte_cnt (or NB-1-byte_cnt when BYTE_ORDER=1).
  - byte_cnt wraps from NB-1 to 0. On the wrap, the completed word is pushed to the FIFO one cycle after the strobe.
  - Latency: stop-bit sample at cycle T, strobe at T+1, push at T+2, dout_vld at T+3 if the FIFO was empty.
- Idle flush:
  - Applies when IDLE_FLUSH>0, byte_cnt>0, and the receiver has stayed in IDLE for IDLE_FLUSH*BIT_CNT cycles.
  - Pushes the partial word with unused lanes zeroed and resets byte_cnt to 0.
  - The idle counter restarts on every start bit.
- FIFO:
  - Pop when dout_vld && dout_ready. dout holds its value while dout_vld=1 and dout_ready=0.
  - A push is accepted when the FIFO is not full or a pop occurs in the same cycle; simultaneous push and pop leave the level unchanged.
  - A push to a full FIFO with no pop drops the word, sets overflow, and still resets byte_cnt.
  - Pointers wrap modulo FIFO_DEPTH. wr_water_level reaches FIFO_DEPTH when full.
- Error flags: a set event in the same cycle as clr_err wins, so the flag stays 1.

Optional Feature:
- Macro UART_PARITY_EN.
- Defined: adds the PARITY state and parameter PARITY_ODD (default 0 = even parity). A parity mismatch sets sticky output parity_err and discards the byte; clr_err also clears parity_err.
- Undefined: frame format is 8N1, there is no PARITY state, and the parity_err port is absent.

Test Plan:
- OUT_W=32, BYTE_ORDER=0; send 0x11,0x22,0x33,0x44 -> one word 0x44332211 with dout_vld high at T+3 after the last stop sample; wr_water_level=1.
- Same bytes with BYTE_ORDER=1 -> word 0x11223344.
- IDLE_FLUSH=4; send 0xAA then idle -> word 0x000000AA after 4*BIT_CNT idle cycles; byte_cnt returns to 0.
- FIFO_DEPTH=4, dout_ready=0; send 5 words -> wr_water_level=4, almost_full=1 (AFULL_TH=3), overflow=1; the 4 words read back in order, the 5th is absent.
- Stop bit forced to 0 on byte 2 of 4 -> frame_err=1 and the byte is dropped; the next 3 valid bytes complete the word; clr_err clears frame_err.
- Start glitch shorter than BIT_CNT/2 -> no strobe; assert sys_rst mid-byte -> all outputs 0 and the next frame is received correctly.
